// File: rtl/imem_loader.sv
// Instruction memory loader: parses a length-prefixed little-endian byte stream
// and issues one-cycle word writes while holding the CPU in reset.
module imem_loader #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             we,
  output logic [31:0]      waddr,
  output logic [31:0]      wdata,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic [2:0] {StIdle, StLenLo, StLenHi, StData, StDone} state_e;

  state_e           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      asm_q, asm_d;
  logic             we_q, we_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [15:0]      hdr;
  logic [CNT_W-1:0] next_cnt;

  assign rx_ready = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign busy     = rx_ready;
  assign cpu_hold = busy;
  assign done     = (state_q == StDone);
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign err      = err_q;
  assign word_cnt = cnt_q;

  assign accept   = rx_valid && rx_ready;
  assign hdr      = {rx_data, len_q[7:0]};
  assign next_cnt = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLenLo;
          err_d      = 1'b0;
          cnt_d      = '0;
          byte_idx_d = '0;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d      = hdr;
          byte_idx_d = '0;
          if (hdr == 16'd0) begin
            state_d = StDone;
          end else if (hdr > 16'(DEPTH)) begin
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          // First byte lands in [7:0] after four right-shifts.
          asm_d      = {rx_data, asm_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {rx_data, asm_q[31:8]};
            waddr_d = 32'(cnt_q) << 2;
            cnt_d   = next_cnt;
            if (16'(next_cnt) == len_q) state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      byte_idx_q <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed sessions plus random loads checked against a
// stream-level model of the expected writes and handshake timing.
module tb_imem_loader;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             rx_ready;
  logic             we;
  logic [31:0]      waddr;
  logic [31:0]      wdata;
  logic             busy;
  logic             cpu_hold;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] word_cnt;

  imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .busy    (busy),
    .cpu_hold(cpu_hold),
    .done    (done),
    .err     (err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed handshakes and writes, time-stamped in cycles.
  int          hs_cyc[$];
  int          we_cyc[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  always @(negedge clk) begin
    if (rx_valid && rx_ready) hs_cyc.push_back(cyc);
    if (we) begin
      we_cyc.push_back(cyc);
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte and hold it until accepted; gap < 0 picks a random gap.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    int g;
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 64) begin
      acc = rx_ready;
      tick();
      n++;
    end
    if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    repeat (g) tick();
  endtask

  // Runs a full session; mid_start >= 0 pulses start before that stream byte.
  task automatic run_session(input logic [7:0] s[$], input int gap, input int mid_start);
    int len;
    int nexp;
    int nsend;
    int hs0;
    int we0;
    int hi;
    bit e;
    logic [31:0] w;
    len  = int'({s[1], s[0]});
    e    = (len > int'(DEPTH));
    nexp = e ? 0 : len;
    nsend = (e || len == 0) ? 2 : 2 + 4 * len;
    hs0 = hs_cyc.size();
    we0 = we_cyc.size();

    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("hold_after_start", 32'(cpu_hold), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
    chk("err_cleared", 32'(err), 32'd0);
    chk("cnt_cleared", 32'(word_cnt), 32'd0);

    for (int i = 0; i < nsend; i++) begin
      if (i == mid_start) begin
        pulse_start();
        chk("busy_after_mid_start", 32'(busy), 32'd1);
      end
      send_byte(s[i], gap);
      if (i < nsend - 1) chk("hold_mid_session", 32'(cpu_hold), 32'd1);
    end

    chk("done_end", 32'(done), 32'd1);
    chk("err_end", 32'(err), 32'(e));
    chk("busy_end", 32'(busy), 32'd0);
    chk("hold_end", 32'(cpu_hold), 32'd0);
    chk("ready_end", 32'(rx_ready), 32'd0);
    chk("word_cnt_end", 32'(word_cnt), 32'(nexp));
    repeat (2) tick();
    chk("done_held", 32'(done), 32'd1);
    chk("we_count", 32'(we_cyc.size() - we0), 32'(nexp));
    for (int i = 0; i < nexp && (we0 + i) < we_cyc.size(); i++) begin
      w = {s[2 + 4*i + 3], s[2 + 4*i + 2], s[2 + 4*i + 1], s[2 + 4*i]};
      chk("waddr", wa_q[we0 + i], 32'(4 * i));
      chk("wdata", wd_q[we0 + i], w);
      hi = hs0 + 2 + 4*i + 3;
      if (hi < hs_cyc.size()) chk("we_latency", 32'(we_cyc[we0 + i] - hs_cyc[hi]), 32'd1);
      else chk("handshake_missing", 32'd0, 32'd1);
    end
  endtask

  initial begin
    logic [7:0] s1[$];
    logic [7:0] s[$];
    int len;
    int hs_before;

    s1 = '{8'h02, 8'h00, 8'h33, 8'h02, 8'h11, 8'h00, 8'hB3, 8'h02, 8'h11, 8'h40};

    #1;
    chk("rst_ready", 32'(rx_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(rx_ready), 32'd0);
    chk("idle_word_cnt", 32'(word_cnt), 32'd0);

    // Full-rate, then one byte every third cycle.
    run_session(s1, 0, -1);
    run_session(s1, 2, -1);

    // Zero-length header.
    s = '{8'h00, 8'h00};
    run_session(s, 0, -1);

    // Oversized header, then extra bytes must be refused.
    s = '{8'h11, 8'h00};
    run_session(s, 0, -1);
    hs_before = hs_cyc.size();
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (4) tick();
    chk("err_ready", 32'(rx_ready), 32'd0);
    rx_valid = 1'b0;
    tick();
    chk("err_no_accept", 32'(hs_cyc.size() - hs_before), 32'd0);

    // Async reset in the middle of word 0.
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(s1[i], 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_hold", 32'(cpu_hold), 32'd0);
    chk("arst_ready", 32'(rx_ready), 32'd0);
    chk("arst_cnt", 32'(word_cnt), 32'd0);
    chk("arst_waddr", waddr, 32'd0);
    chk("arst_wdata", wdata, 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    run_session(s1, 0, -1);

    // start mid-DATA is ignored; next start from DONE begins a fresh load.
    run_session(s1, 1, 4);
    run_session(s1, 0, -1);

    // Maximum legal length.
    s.delete();
    s.push_back(8'(DEPTH));
    s.push_back(8'h00);
    for (int i = 0; i < 4 * int'(DEPTH); i++) s.push_back(8'($urandom));
    run_session(s, 0, -1);

    // Random sessions, occasionally with an illegal length.
    for (int k = 0; k < 10; k++) begin
      s.delete();
      len = int'($urandom_range(1, DEPTH));
      if ($urandom_range(0, 4) == 0) len = int'(DEPTH) + int'($urandom_range(1, 400));
      s.push_back(8'(len));
      s.push_back(8'(len >> 8));
      if (len <= int'(DEPTH)) begin
        for (int i = 0; i < 4 * len; i++) s.push_back(8'($urandom));
      end
      run_session(s, -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
